// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock blocks: BCD digit type,
// per-field wrap limits and the default system clock rate.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int CLK_FREQ_HZ_DEFAULT = 50_000_000;

endpackage : clock_pkg

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps MAX -> 00. The carry strobe is
// combinational and marks the cycle in which that wrap is being taken.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output bcd_t ones,
  output bcd_t tens,
  output logic carry
);

  localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);
  localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);

  bcd_t ones_q, ones_d;
  bcd_t tens_q, tens_d;
  logic at_max;

  // Next-digit logic: terminal count wraps both digits, 9 rolls into tens.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    at_max = (ones_q == MAX_ONES) && (tens_q == MAX_TENS);
    carry  = inc && at_max;
    if (inc) begin
      if (at_max) begin
        ones_d = '0;
        tens_d = '0;
      end else if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule : bcd_mod_counter

// File: rtl/bcd_time_counter.sv
// 24-hour BCD timekeeping core: prescaler down to a 1 Hz tick, cascaded
// seconds/minutes/hours counters, and set pulses that take priority over
// the carry into their own field.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       setMinute,
  input  logic       setHour,
  output logic [3:0] secOnes,
  output logic [3:0] secTens,
  output logic [3:0] minOnes,
  output logic [3:0] minTens,
  output logic [3:0] hourOnes,
  output logic [3:0] hourTens,
  output logic       secondTick
);

  localparam int            CW      = $clog2(CLK_FREQ_HZ);
  localparam logic [CW-1:0] PRE_MAX = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] pre_q, pre_d;
  logic          tick;
  logic          sec_tick_q, sec_tick_d;

  logic sec_carry;
  logic min_inc, min_wrap, min_carry;
  logic hour_inc;
  logic hour_wrap_unused;

  // Prescaler: counts only while running; tick on the terminal count.
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (run) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    sec_tick_d = tick;
  end

  // Prescaler and registered tick, which lines up with the new seconds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  // Set pulses advance their field once and swallow any coincident carry,
  // so a set plus a carry is still +1 and the set never ripples upward.
  always_comb begin
    min_inc   = setMinute | sec_carry;
    min_carry = min_wrap & ~setMinute;
    hour_inc  = setHour | min_carry;
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (tick),
    .ones (secOnes),
    .tens (secTens),
    .carry(sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (min_inc),
    .ones (minOnes),
    .tens (minTens),
    .carry(min_wrap)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (hour_inc),
    .ones (hourOnes),
    .tens (hourTens),
    .carry(hour_wrap_unused)
  );

  assign secondTick = sec_tick_q;

endmodule : bcd_time_counter

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with a 4-cycle second.
module tb_bcd_time_counter;

  logic       clk, rst_n, run, setMinute, setHour;
  logic [3:0] secOnes, secTens, minOnes, minTens, hourOnes, hourTens;
  logic       secondTick;
  logic [23:0] tm;

  int total = 0;
  int bad   = 0;

  bcd_time_counter #(.CLK_FREQ_HZ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .setMinute (setMinute),
    .setHour   (setHour),
    .secOnes   (secOnes),
    .secTens   (secTens),
    .minOnes   (minOnes),
    .minTens   (minTens),
    .hourOnes  (hourOnes),
    .hourTens  (hourTens),
    .secondTick(secondTick)
  );

  assign tm = {hourTens, hourOnes, minTens, minOnes, secTens, secOnes};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; setMinute = 1'b0; setHour = 1'b0;
    #3;
    total++; if (tm !== 24'h000000) begin bad++; $display("FAIL reset_time: got %h want 000000", tm); end
    total++; if (secondTick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", secondTick); end
    cyc(2);
    @(negedge clk) rst_n = 1'b1;
    cyc(1);
    total++; if (tm !== 24'h000000) begin bad++; $display("FAIL reset_release: got %h want 000000", tm); end
  endtask

  task automatic test_prescaler;
    run = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      total++;
      if (secondTick !== ((k % 4) == 0)) begin
        bad++; $display("FAIL tick_cadence cyc%0d: got %b want %b", k, secondTick, (k % 4) == 0);
      end
    end
    total++; if (tm !== 24'h000010) begin bad++; $display("FAIL after40: got %h want 000010", tm); end
  endtask

  task automatic test_rollover;
    cyc(49 * 4);
    total++; if (tm !== 24'h000059) begin bad++; $display("FAIL to_000059: got %h want 000059", tm); end
    cyc(4);
    total++; if (tm !== 24'h000100) begin bad++; $display("FAIL sec_carry: got %h want 000100", tm); end
    cyc(3539 * 4);
    total++; if (tm !== 24'h005959) begin bad++; $display("FAIL to_005959: got %h want 005959", tm); end
    cyc(4);
    total++; if (tm !== 24'h010000) begin bad++; $display("FAIL min_carry: got %h want 010000", tm); end
    run = 1'b0;
    setHour = 1'b1; cyc(8); setHour = 1'b0;
    total++; if (tm !== 24'h090000) begin bad++; $display("FAIL set_09: got %h want 090000", tm); end
    setMinute = 1'b1; cyc(59); setMinute = 1'b0;
    total++; if (tm !== 24'h095900) begin bad++; $display("FAIL set_0959: got %h want 095900", tm); end
    run = 1'b1; cyc(59 * 4);
    total++; if (tm !== 24'h095959) begin bad++; $display("FAIL to_095959: got %h want 095959", tm); end
    cyc(4);
    total++; if (tm !== 24'h100000) begin bad++; $display("FAIL hour_09_10: got %h want 100000", tm); end
    run = 1'b0;
    setHour = 1'b1; cyc(10); setHour = 1'b0;
    total++; if (tm !== 24'h200000) begin bad++; $display("FAIL hour_19_20: got %h want 200000", tm); end
    setHour = 1'b1; cyc(3); setHour = 1'b0;
    setMinute = 1'b1; cyc(59); setMinute = 1'b0;
    run = 1'b1; cyc(59 * 4);
    total++; if (tm !== 24'h235959) begin bad++; $display("FAIL to_235959: got %h want 235959", tm); end
    cyc(4);
    total++; if (tm !== 24'h000000) begin bad++; $display("FAIL full_wrap: got %h want 000000", tm); end
    total++; if (secondTick !== 1'b1) begin bad++; $display("FAIL full_wrap_tick: got %b want 1", secondTick); end
    run = 1'b0;
  endtask

  task automatic test_freeze;
    run = 1'b1; cyc(2); run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      total++; if (secondTick !== 1'b0) begin bad++; $display("FAIL frozen_tick cyc%0d: got %b want 0", k, secondTick); end
    end
    total++; if (tm !== 24'h000000) begin bad++; $display("FAIL frozen_time: got %h want 000000", tm); end
    run = 1'b1; cyc(1);
    total++; if (secondTick !== 1'b0) begin bad++; $display("FAIL resume_early: got %b want 0", secondTick); end
    cyc(1);
    total++; if (secondTick !== 1'b1) begin bad++; $display("FAIL resume_tick: got %b want 1", secondTick); end
    total++; if (tm !== 24'h000001) begin bad++; $display("FAIL resume_time: got %h want 000001", tm); end
    run = 1'b0;
  endtask

  task automatic test_set_carry;
    setMinute = 1'b1; cyc(59); setMinute = 1'b0;
    total++; if (tm !== 24'h005901) begin bad++; $display("FAIL set_sec_untouched: got %h want 005901", tm); end
    run = 1'b1; cyc(58 * 4 + 3);
    total++; if (tm !== 24'h005959) begin bad++; $display("FAIL pre_set_carry: got %h want 005959", tm); end
    setMinute = 1'b1; cyc(1); setMinute = 1'b0;
    run = 1'b0;
    total++; if (tm !== 24'h000000) begin bad++; $display("FAIL set_suppresses_carry: got %h want 000000", tm); end
    total++; if (secondTick !== 1'b1) begin bad++; $display("FAIL set_carry_tick: got %b want 1", secondTick); end
  endtask

  task automatic test_back_to_back;
    setHour = 1'b1; cyc(22); setHour = 1'b0;
    setMinute = 1'b1; cyc(58); setMinute = 1'b0;
    run = 1'b1; cyc(30 * 4); run = 1'b0;
    total++; if (tm !== 24'h225830) begin bad++; $display("FAIL to_225830: got %h want 225830", tm); end
    setHour = 1'b1; setMinute = 1'b1; cyc(1); setHour = 1'b0; setMinute = 1'b0;
    total++; if (tm !== 24'h235930) begin bad++; $display("FAIL both_set: got %h want 235930", tm); end
    setHour = 1'b1; cyc(1); setHour = 1'b0;
    total++; if (tm !== 24'h005930) begin bad++; $display("FAIL hour_23_00: got %h want 005930", tm); end
  endtask

  task automatic test_async_reset;
    setHour = 1'b1; cyc(13); setHour = 1'b0;
    setMinute = 1'b1; cyc(28); setMinute = 1'b0;
    run = 1'b1; cyc(11 * 4);
    total++; if (tm !== 24'h132741) begin bad++; $display("FAIL to_132741: got %h want 132741", tm); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tm !== 24'h000000) begin bad++; $display("FAIL async_reset_time: got %h want 000000", tm); end
    total++; if (secondTick !== 1'b0) begin bad++; $display("FAIL async_reset_tick: got %b want 0", secondTick); end
    run = 1'b0;
    cyc(2);
    @(negedge clk) rst_n = 1'b1;
    cyc(3);
    total++; if (tm !== 24'h000000) begin bad++; $display("FAIL post_reset_hold: got %h want 000000", tm); end
  endtask

  initial begin
    test_reset;
    test_prescaler;
    test_rollover;
    test_freeze;
    test_set_carry;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd_time_counter
